// File: rtl/morse_pkg.sv
// Shared state encoding and default timing constants for the SOS sequencer.
package morse_pkg;

  localparam int unsigned DefaultT1ms   = 49_999;
  localparam int unsigned DefaultGapMs  = 300;
  localparam int unsigned DefaultWordMs = 700;

  typedef enum logic [2:0] {
    StIdle,
    StSendS1,
    StGap1,
    StSendO,
    StGap2,
    StSendS2,
    StWgap,
    StDone
  } state_e;

  function automatic logic is_send_s(input state_e st);
    return (st == StSendS1) || (st == StSendS2);
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running 1 ms prescaler: one-cycle Tick every T1MS+1 clocks, restarted by Clr.
module ms_tick_gen import morse_pkg::*; #(
  parameter int unsigned T1MS = DefaultT1ms
) (
  input  logic CLK,
  input  logic RST,
  input  logic Clr,
  output logic Tick
);

  localparam int unsigned CntW = (T1MS > 0) ? $clog2(T1MS + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(T1MS);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (Clr || (cnt_q == CntMax)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign Tick = (cnt_q == CntMax);

endmodule

// File: rtl/morse_seq_ctrl.sv
// SOS word sequencer driving external S/O symbol generators with ms-timed gaps.
// Abort support is compiled in only when MORSE_SEQ_ABORT_EN is defined.
module morse_seq_ctrl import morse_pkg::*; #(
  parameter int unsigned T1MS    = DefaultT1ms,
  parameter int unsigned GAP_MS  = DefaultGapMs,
  parameter int unsigned WORD_MS = DefaultWordMs,
  parameter int unsigned REPEATS = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Start_Sig,
  input  logic       Abort_Sig,
  output logic       S_Start,
  input  logic       S_Done,
  input  logic       S_Pin,
  output logic       O_Start,
  input  logic       O_Done,
  input  logic       O_Pin,
  output logic       Pin_Out,
  output logic       Busy,
  output logic       Done_Sig,
  output logic [7:0] Word_Cnt
);

  localparam logic [9:0] GapLast  = 10'(GAP_MS - 1);
  localparam logic [9:0] WordLast = 10'(WORD_MS - 1);
  localparam logic [7:0] RepCnt   = 8'(REPEATS);

  state_e     state_q, state_d;
  logic [9:0] ms_q, ms_d;
  logic [7:0] word_cnt_q, word_cnt_d;
  logic       s_start_q, o_start_q, busy_q, done_q;
  logic       tick, st_chg, abort;

`ifdef MORSE_SEQ_ABORT_EN
  assign abort = Abort_Sig;
`else
  // Port kept so both builds share one pinout; tied off here.
  assign abort = Abort_Sig & 1'b0;
`endif

  ms_tick_gen #(
    .T1MS (T1MS)
  ) u_ms_tick_gen (
    .CLK  (CLK),
    .RST  (RST),
    .Clr  (st_chg),
    .Tick (tick)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (Start_Sig) state_d = StSendS1;
      StSendS1: if (S_Done) state_d = StGap1;
      StGap1:   if (tick && (ms_q == GapLast)) state_d = StSendO;
      StSendO:  if (O_Done) state_d = StGap2;
      StGap2:   if (tick && (ms_q == GapLast)) state_d = StSendS2;
      StSendS2: if (S_Done) state_d = StWgap;
      StWgap: begin
        if (tick && (ms_q == WordLast)) begin
          state_d = ((REPEATS != 0) && (word_cnt_q == RepCnt)) ? StDone : StSendS1;
        end
      end
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    // Start release and abort override every other event.
    if ((state_q != StIdle) && !Start_Sig) state_d = StIdle;
    if (abort) state_d = StIdle;
  end

  assign st_chg = (state_d != state_q);

  always_comb begin
    ms_d = ms_q;
    if (st_chg) begin
      ms_d = '0;
    end else if (tick) begin
      ms_d = ms_q + 10'd1;
    end
  end

  always_comb begin
    word_cnt_d = word_cnt_q;
    if (state_d == StIdle) begin
      word_cnt_d = '0;
    end else if ((state_q == StSendS2) && (state_d == StWgap) && (word_cnt_q != 8'hFF)) begin
      word_cnt_d = word_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      ms_q       <= '0;
      word_cnt_q <= '0;
      s_start_q  <= 1'b0;
      o_start_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ms_q       <= ms_d;
      word_cnt_q <= word_cnt_d;
      s_start_q  <= is_send_s(state_d);
      o_start_q  <= (state_d == StSendO);
      busy_q     <= (state_d != StIdle);
      done_q     <= (state_d == StDone);
    end
  end

  always_comb begin
    Pin_Out = 1'b0;
    if (is_send_s(state_q)) begin
      Pin_Out = S_Pin;
    end else if (state_q == StSendO) begin
      Pin_Out = O_Pin;
    end
  end

  assign S_Start  = s_start_q;
  assign O_Start  = o_start_q;
  assign Busy     = busy_q;
  assign Done_Sig = done_q;
  assign Word_Cnt = word_cnt_q;

endmodule

// File: doc/morse_seq_ctrl.md
MORSE_SEQ_CTRL -- requirements
Module: morse_seq_ctrl

Interface
REQ-001 SHALL have parameter: T1MS, 49_999, CLK cycles per 1 ms minus 1 (50 MHz).
REQ-002 SHALL have parameter: GAP_MS, 300, inter-symbol gap in ms, 10-bit, range 1..1023.
REQ-003 SHALL have parameter: WORD_MS, 700, inter-word gap in ms, 10-bit, range 1..1023.
REQ-004 SHALL have parameter: REPEATS, 3, words per run, 8-bit; 0 = repeat until stopped.
REQ-005 SHALL have port: CLK  in  1  single system clock, all logic on rising edge.
REQ-006 SHALL have port: RST  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port: Start_Sig  in  1  level request; run proceeds while high.
REQ-008 SHALL have port: Abort_Sig  in  1  one-cycle abort request.
REQ-009 SHALL have port: S_Start  out  1  level start to the S-symbol generator.
REQ-010 SHALL have port: S_Done  in  1  one-cycle done pulse from the S generator.
REQ-011 SHALL have port: S_Pin  in  1  S generator output pin.
REQ-012 SHALL have port: O_Start  out  1  level start to the O-symbol generator.
REQ-013 SHALL have port: O_Done  in  1  one-cycle done pulse from the O generator.
REQ-014 SHALL have port: O_Pin  in  1  O generator output pin.
REQ-015 SHALL have port: Pin_Out  out  1  muxed key output to the buzzer/LED.
REQ-016 SHALL have port: Busy  out  1  high in every state except IDLE.
REQ-017 SHALL have port: Done_Sig  out  1  one-cycle pulse at run completion.
REQ-018 SHALL have port: Word_Cnt  out  8  words completed in the current run.

Function
REQ-019 SHALL implement states IDLE, SEND_S1, GAP1, SEND_O, GAP2, SEND_S2, WGAP, DONE.
REQ-020 SHALL go IDLE->SEND_S1 on the first cycle Start_Sig is high.
REQ-021 SHALL hold S_Start high throughout SEND_S1/SEND_S2 and O_Start high throughout SEND_O; never both high.
REQ-022 SHALL leave a SEND state on the cycle after the matching Done pulse, deasserting that Start in the same cycle.
REQ-023 SHALL ignore a Done pulse from the generator not currently selected.
REQ-024 SHALL time GAP1/GAP2 for GAP_MS and WGAP for WORD_MS using 1 ms ticks; the ms counter clears on every state entry.
REQ-025 SHALL move SEND_S2->WGAP, incrementing Word_Cnt (saturating at 255).
REQ-026 SHALL, at WGAP end, go to DONE if REPEATS!=0 and Word_Cnt==REPEATS, else to SEND_S1.
REQ-027 SHALL pulse Done_Sig for exactly one cycle in DONE, then go to IDLE and clear Word_Cnt.
REQ-028 SHALL drive Pin_Out = S_Pin in SEND_S1/SEND_S2, O_Pin in SEND_O, 0 in all other states.
REQ-029 SHALL, if Start_Sig drops in any non-IDLE state, deassert both Starts and go to IDLE the next cycle without Done_Sig.
REQ-030 SHALL give Abort_Sig priority over all other events, with the same effect as REQ-029.
REQ-031 SHALL register all outputs except Pin_Out, which is a combinational mux selected by the registered state.

Reset
REQ-032 SHALL, while RST is high, force state IDLE, S_Start=0, O_Start=0, Done_Sig=0, Busy=0, Word_Cnt=0, and clear the tick and ms counters; Pin_Out is therefore 0.
REQ-033 SHALL resume from IDLE on the first clock after RST falls, including after a reset asserted mid-word.

Configuration
REQ-034 SHALL compile abort support only when MORSE_SEQ_ABORT_EN is defined; otherwise Abort_Sig stays a port but is ignored and only REQ-029 applies.

Structure
REQ-035 SHALL place the state encoding and the default T1MS, GAP_MS and WORD_MS constants in a shared package, morse_pkg.
REQ-036 SHALL use one sub-module, ms_tick_gen (T1MS counter with a clear input, one-cycle tick output), instantiated once.

Verification
All scenarios run with T1MS=9, GAP_MS=3, WORD_MS=7 and behavioural generators whose Done pulse comes 20 cycles after Start rises.
REQ-037 SHALL check: REPEATS=1, Start held -> S_Start, gap of 30 cycles, O_Start, gap of 30 cycles, S_Start, 70-cycle WGAP, one Done_Sig pulse, Word_Cnt=1 then 0.
REQ-038 SHALL check: REPEATS=3 -> exactly 3 words, Word_Cnt steps 1,2,3, a single Done_Sig.
REQ-039 SHALL check: Start_Sig dropped in the middle of SEND_O -> O_Start=0 and IDLE next cycle, no Done_Sig, Pin_Out=0.
REQ-040 SHALL check: O_Done injected during SEND_S1 -> no state change; Pin_Out tracks S_Pin only.
REQ-041 SHALL check: RST pulsed in GAP2 -> all outputs at reset values next cycle; a fresh run then starts at SEND_S1.
REQ-042 SHALL check: with MORSE_SEQ_ABORT_EN defined, Abort_Sig in WGAP -> IDLE next cycle; without it, the same stimulus has no effect.
